reqgnt_cov_monitor: RTL

Synthesizable N-channel request/grant protocol monitor that checks `$rose(req) |-> ##[1:MAX_LAT] gnt` per channel and counts antecedent firings, passes, failures and dropped requests. At end of test it reports which channels were vacuous, meaning the antecedent never fired. It sits beside arbiter/handshake DUTs in tutorial benches and gives a hardware-visible answer to "did the check ever actually run?".

---
 rtl/reqgnt_mon_pkg.sv | 22 ++
 rtl/reqgnt_mon_chan.sv | 121 ++++++++++++
 rtl/reqgnt_cov_monitor.sv | 98 +++++++++
 3 files changed

// File: rtl/reqgnt_mon_pkg.sv
// reqgnt_mon_pkg
// Shared types and helpers for the request/grant coverage monitor.
//   mon_state_t : per-channel monitor state (IDLE / WAIT)
//   sat_inc     : saturating increment for counters up to 32 bits wide
package reqgnt_mon_pkg;

  typedef enum logic {IDLE, WAIT} mon_state_t;

  // Increments val unless it already holds the all-ones value of a
  // width-bit counter; callers cast the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned width);
    logic [32:0] max_v;
    max_v = (33'd1 << width) - 33'd1;
    if ({1'b0, val} >= max_v) begin
      return val;
    end else begin
      return val + 32'd1;
    end
  endfunction

endpackage

// File: rtl/reqgnt_mon_chan.sv
// reqgnt_mon_chan
// One monitored channel: checks that a request rise is followed by a grant
// within MAX_LAT cycles and keeps saturating event counters.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   rise          : request rising edge (detected by the parent)
//   gnt           : grant for this channel
//   fire_cnt      : antecedent firings
//   pass_cnt      : grants inside the window
//   fail_cnt      : window timeouts
//   drop_cnt      : rises seen while already waiting
//   fail_pulse    : one-cycle pulse in the cycle after a timeout
//   fired_next    : fire count will be non-zero after this edge
//   wait_next     : channel will be in WAIT after this edge
module reqgnt_mon_chan
  import reqgnt_mon_pkg::*;
#(
  parameter int MAX_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise,
  input  logic             gnt,
  output logic [CNT_W-1:0] fire_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             fail_pulse,
  output logic             fired_next,
  output logic             wait_next
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAX_LAT - 1);

  mon_state_t       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] fire_cnt_q, fire_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             fail_pulse_q, fail_pulse_d;

  // Next-state logic for the window FSM, latency counter and event counters.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    fire_cnt_d   = fire_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    fail_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A grant in the rise cycle is ignored: the window opens next cycle.
        if (rise) begin
          state_d    = WAIT;
          lat_d      = '0;
          fire_cnt_d = CNT_W'(sat_inc(32'(fire_cnt_q), CNT_W));
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        lat_d = lat_q + LAT_W'(1);
        // The window is never restarted; a rise here, even on the exit
        // cycle, is only counted as a drop.
        if (rise) begin
          drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
        if (gnt) begin
          pass_cnt_d = CNT_W'(sat_inc(32'(pass_cnt_q), CNT_W));
          state_d    = IDLE;
        end else if (lat_q == LAT_LAST) begin
          fail_cnt_d   = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_W));
          fail_pulse_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      fire_cnt_q   <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      fire_cnt_q   <= fire_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      fail_pulse_q <= fail_pulse_d;
    end
  end

  assign fire_cnt   = fire_cnt_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign fail_pulse = fail_pulse_q;
  // The report samples post-update state so a firing in the done cycle counts.
  assign fired_next = (fire_cnt_d != '0);
  assign wait_next  = (state_d == WAIT);

endmodule

// File: rtl/reqgnt_cov_monitor.sv
// reqgnt_cov_monitor
// N-channel monitor for $rose(req) |-> ##[1:MAX_LAT] gnt with coverage
// counters and an end-of-test vacuity report.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req, gnt   : per-channel request / grant
//   done       : end-of-test strobe
//   fire_cnt, pass_cnt, fail_cnt, drop_cnt : packed per-channel counters,
//                channel i at [i*CNT_W +: CNT_W]
//   fail_pulse : per-channel timeout pulse
//   rpt_valid  : report strobe, one cycle after done
//   vacuous    : channels that never fired (held from the last report)
//   pending    : channels waiting at the report (held from the last report)
module reqgnt_cov_monitor
  import reqgnt_mon_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MAX_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH-1:0]       gnt,
  input  logic                 done,
  output logic [NCH*CNT_W-1:0] fire_cnt,
  output logic [NCH*CNT_W-1:0] pass_cnt,
  output logic [NCH*CNT_W-1:0] fail_cnt,
  output logic [NCH*CNT_W-1:0] drop_cnt,
  output logic [NCH-1:0]       fail_pulse,
  output logic                 rpt_valid,
  output logic [NCH-1:0]       vacuous,
  output logic [NCH-1:0]       pending
);

  logic [NCH-1:0] req_q, req_d;
  logic [NCH-1:0] vacuous_q, vacuous_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic           rpt_valid_q, rpt_valid_d;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fired_next;
  logic [NCH-1:0] wait_next;

  // req_q resets to 0, so a request already high after reset is a rise.
  assign rise = req & ~req_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    reqgnt_mon_chan #(
      .MAX_LAT (MAX_LAT),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .rise       (rise[i]),
      .gnt        (gnt[i]),
      .fire_cnt   (fire_cnt[i*CNT_W +: CNT_W]),
      .pass_cnt   (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt   (fail_cnt[i*CNT_W +: CNT_W]),
      .drop_cnt   (drop_cnt[i*CNT_W +: CNT_W]),
      .fail_pulse (fail_pulse[i]),
      .fired_next (fired_next[i]),
      .wait_next  (wait_next[i])
    );
  end

  // Report capture: snapshot on done, otherwise hold the previous report.
  always_comb begin
    req_d       = req;
    rpt_valid_d = done;
    if (done) begin
      vacuous_d = ~fired_next;
      pending_d = wait_next;
    end else begin
      vacuous_d = vacuous_q;
      pending_d = pending_q;
    end
  end

  // Request history and report registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '0;
      rpt_valid_q <= 1'b0;
      vacuous_q   <= '0;
      pending_q   <= '0;
    end else begin
      req_q       <= req_d;
      rpt_valid_q <= rpt_valid_d;
      vacuous_q   <= vacuous_d;
      pending_q   <= pending_d;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign vacuous   = vacuous_q;
  assign pending   = pending_q;

endmodule
